// File: rtl/inst_decode_stage.sv
// RV32I OP/OP-IMM decode stage with registered output and one-entry skid.
// Optional macro DECODE_STATS_EN adds a saturating decoded-instruction counter.
module inst_decode_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_inst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [WIDTH-1:0]  out_imm,
  output logic [3:0]        out_alu_op,
  output logic              out_use_imm,
  output logic              out_reg_we,
  output logic              halt,
  output logic              illegal,
  output logic [15:0]       inst_count
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_SLT = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SRL = 4'd5,
    ALU_OR  = 4'd6,
    ALU_AND = 4'd7,
    ALU_NOP = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [WIDTH-1:0]  imm;
    logic [3:0]        alu_op;
    logic              use_imm;
    logic              reg_we;
  } bundle_t;

  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  bundle_t    dec;

  bundle_t out_q, out_n;
  bundle_t skid_q, skid_n;
  logic    out_v_n, skid_full, skid_v_n;
  logic    halt_n, illegal_n, ready_n;
  logic    acc, is_zero, fwd, drain;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  // Split the incoming word; unsupported encodings become a bubble.
  always_comb begin
    dec         = '0;
    legal       = 1'b0;
    dec.rd      = in_inst[7 +: REG_AW];
    dec.rs1     = in_inst[15 +: REG_AW];
    dec.rs2     = in_inst[20 +: REG_AW];
    dec.alu_op  = ALU_NOP;
    case (opcode)
      OPC_IMM: begin
        case (funct3)
          3'b000: begin
            legal      = 1'b1;
            dec.alu_op = ALU_ADD;
            dec.imm    = {{(WIDTH-12){in_inst[31]}},
                          in_inst[31:20]};
          end
          3'b001: if (funct7 == F7_BASE) begin
            legal      = 1'b1;
            dec.alu_op = ALU_SLL;
            dec.imm    = {{(WIDTH-5){1'b0}},
                          in_inst[24:20]};
          end
          3'b101: if (funct7 == F7_BASE) begin
            legal      = 1'b1;
            dec.alu_op = ALU_SRL;
            dec.imm    = {{(WIDTH-5){1'b0}},
                          in_inst[24:20]};
          end
          default: ;
        endcase
        if (legal) begin
          dec.rs2     = '0;
          dec.use_imm = 1'b1;
        end
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  dec.alu_op = ALU_ADD;
            3'b001:  dec.alu_op = ALU_SLL;
            3'b010:  dec.alu_op = ALU_SLT;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  dec.alu_op = ALU_SRL;
            3'b110:  dec.alu_op = ALU_OR;
            3'b111:  dec.alu_op = ALU_AND;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT &&
                     funct3 == 3'b000) begin
          legal      = 1'b1;
          dec.alu_op = ALU_SUB;
        end
      end
      default: ;
    endcase
    if (!legal) begin
      dec.alu_op = ALU_NOP;
      dec.imm    = '0;
    end
    dec.reg_we = legal && (dec.rd != '0);
  end

  assign acc     = in_valid && in_ready;
  assign is_zero = (in_inst == '0);
  assign fwd     = acc && !is_zero;
  assign drain   = out_valid && out_ready;

  // Output/skid steering: skid drains ahead of any new word.
  always_comb begin
    out_n    = out_q;
    out_v_n  = out_valid;
    skid_n   = skid_q;
    skid_v_n = skid_full;
    if (drain) begin
      if (skid_full) begin
        out_n   = skid_q;
        out_v_n = 1'b1;
        if (fwd) begin
          skid_n = dec;
        end else begin
          skid_v_n = 1'b0;
        end
      end else if (fwd) begin
        out_n = dec;
      end else begin
        out_v_n = 1'b0;
      end
    end else if (!out_valid) begin
      if (fwd) begin
        out_n   = dec;
        out_v_n = 1'b1;
      end
    end else if (fwd) begin
      skid_n   = dec;
      skid_v_n = 1'b1;
    end
    halt_n    = halt || (acc && is_zero);
    illegal_n = illegal || (fwd && !legal);
    ready_n   = !skid_v_n && !halt_n;
  end

  // Pipeline, skid and sticky status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      skid_q    <= '0;
      skid_full <= 1'b0;
      halt      <= 1'b0;
      illegal   <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_q     <= out_n;
      out_valid <= out_v_n;
      skid_q    <= skid_n;
      skid_full <= skid_v_n;
      halt      <= halt_n;
      illegal   <= illegal_n;
      in_ready  <= ready_n;
    end
  end

  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_imm     = out_q.imm;
  assign out_alu_op  = out_q.alu_op;
  assign out_use_imm = out_q.use_imm;
  assign out_reg_we  = out_q.reg_we;

`ifdef DECODE_STATS_EN
  logic [15:0] cnt_q;

  // Count real (non-bubble) bundles taken by execute, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drain && out_q.alu_op != ALU_NOP &&
                 cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign inst_count = cnt_q;
`else
  assign inst_count = 16'h0;
`endif

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- Decode stage directly downstream of the instruction ROM/fetch block.
- Accepts 32-bit RV32I words (OP and OP-IMM subset) over a valid/ready handshake.
- Splits each word into register indices, immediate, ALU op code and write-enable, then presents them to the execute stage through a registered output with a one-entry skid buffer.
- Detects the all-zero NO-OP terminator and halts intake.

Parameters:
- WIDTH, 32, instruction/immediate width.
- REG_AW, 5, register index width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_inst  input  WIDTH  instruction word from fetch.
- in_valid  input  1  in_inst is valid this cycle.
- in_ready  output  1  stage accepts in_inst this cycle.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute stage consumes bundle.
- out_rd  output  REG_AW  destination register.
- out_rs1  output  REG_AW  source register 1.
- out_rs2  output  REG_AW  source register 2; 0 for OP-IMM.
- out_imm  output  WIDTH  immediate.
- out_alu_op  output  4  ALU operation.
- out_use_imm  output  1  operand B is out_imm.
- out_reg_we  output  1  write rd.
- halt  output  1  sticky; NO-OP terminator seen.
- illegal  output  1  sticky; unsupported encoding seen.
- inst_count  output  16  decoded-instruction counter (optional feature).

Behaviour:
- Reset: out_valid=0, all out_* fields=0, halt=0, illegal=0, inst_count=0, skid buffer empty. in_ready=1 from the first cycle after reset. Reset mid-operation discards both held bundles.
- Transfer occurs when valid and ready are both high on a rising clk edge.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 if the output register is empty or draining.
- Skid buffer:
  - If the output is stalled (out_valid=1, out_ready=0) when a word is accepted, the decoded bundle goes into the skid register.
  - in_ready = !skid_full && !halt, as a registered signal.
  - When the output drains, the skid content moves to the output before any new word.
  - Order is always preserved. No bundle is ever dropped or duplicated.
- Decode rules (opcode = inst[6:0], funct3 = [14:12], funct7 = [31:25]):
  - OP-IMM 0010011:
    - funct3 000: ADDI, imm = sign-extended inst[31:20].
    - funct3 001 with funct7 0000000: SLLI, imm = zero-extended inst[24:20].
    - funct3 101 with funct7 0000000: SRLI, imm as SLLI.
    - use_imm=1, rs2=0.
  - OP 0110011 with funct7 0000000:
    - funct3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - OP 0110011 with funct7 0100000:
    - funct3 000 SUB.
  - ALU op encoding: ADD=0, SUB=1, SLL=2, SLT=3, XOR=4, SRL=5, OR=6, AND=7, NOP=15.
  - out_reg_we = 1 for legal instructions with rd != 0, otherwise 0.
- Halt:
  - An accepted word of 32'h0 is not forwarded downstream. It sets halt on the next edge, and in_ready=0 from then until reset.
  - Bundles already held still drain normally.
- Illegal encodings (any other word):
  - Forwarded as a bubble bundle: alu_op=15, reg_we=0, use_imm=0, imm=0, fields decoded raw.
  - The illegal flag becomes sticky 1.
- Simultaneous skid-drain and new accept in the same cycle: the skid content goes to the output and the new word fills the skid register.

Optional Feature:
- Macro: DECODE_STATS_EN.
- Defined:
  - inst_count increments by 1 on each output transfer (out_valid && out_ready) whose alu_op != 15.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: inst_count is tied to 16'h0 and no counter flops exist.

Test Plan:
- Reset, then send 32'h00A08093 with out_ready=1 -> next cycle out_valid=1, rd=1, rs1=1, imm=10, alu_op=0, use_imm=1, reg_we=1.
- Send 32'h40610533 -> rd=10, rs1=2, rs2=6, alu_op=1, use_imm=0, reg_we=1. Send 32'h00115293 -> rd=5, rs1=2, imm=1, alu_op=5.
- Hold out_ready=0 and offer the 12-word program back-to-back -> exactly 2 accepted, then in_ready=0. Raise out_ready -> all 12 bundles emerge in order, none lost or duplicated.
- Send 32'h00000000 after 3 words -> halt=1 on the next cycle, in_ready stays 0, the 3 prior bundles drain, and no 4th out_valid occurs. With DECODE_STATS_EN defined, inst_count=3.
- Send 32'h02208033 (funct7 0000001) -> bubble with alu_op=15, reg_we=0. illegal=1 and stays 1. inst_count unchanged.
- Assert rst for 1 cycle while both output and skid are full -> next cycle out_valid=0, halt=0, illegal=0, in_ready=1.
